// File: rtl/tx_share_arbiter.sv
// Shares one 7-bit serial transmitter among NREQ level requesters, with inter-frame gap.
// Define TX_SHARE_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round robin.
module tx_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int STOP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  input  logic [7*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         ack,
  output logic                    tx_start,
  output logic [6:0]              tx_data,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] gnt_id
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t          r_state, w_state_nxt;
  logic [4:0]      r_cnt, w_cnt_nxt;
  logic [IDW-1:0]  r_ptr, w_ptr_nxt;
  logic [IDW-1:0]  r_gnt_id, w_gnt_nxt;
  logic [NREQ-1:0] r_ack, w_ack_nxt;
  logic            r_tx_start, w_start_nxt;
  logic            r_busy, w_busy_nxt;
  logic [6:0]      r_tx_data, w_data_nxt;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_idx;
  logic            w_found;
  logic            w_grant;
  logic [6:0]      w_pay;

  // Winner selection; the round-robin search starts just after the last grant.
  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
`ifdef TX_SHARE_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = IDW'(i);
      if (req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
`else
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = IDW'((int'(r_ptr) + i) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    w_pay = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) w_pay = req_data[7*i +: 7];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt_id;
    w_ack_nxt   = '0;
    w_start_nxt = 1'b0;
    w_data_nxt  = r_tx_data;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) w_grant = 1'b1;
      end
      FRAME: begin
        if (r_cnt != 5'd0)  w_cnt_nxt   = r_cnt - 5'd1;
        else if (w_found)   w_grant     = 1'b1;
        else                w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // tx_data only moves on a grant, so it stays stable for the whole frame and gap.
    if (w_grant) begin
      w_ack_nxt   = NREQ'(1) << w_win;
      w_data_nxt  = w_pay;
      w_start_nxt = 1'b1;
      w_gnt_nxt   = w_win;
      w_ptr_nxt   = w_win;
      w_cnt_nxt   = 5'(8 + STOP_CYCLES);
      w_state_nxt = FRAME;
    end
    w_busy_nxt = (w_state_nxt == FRAME);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ptr      <= IDW'(NREQ - 1);
      r_gnt_id   <= '0;
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gnt_id   <= w_gnt_nxt;
      r_ack      <= w_ack_nxt;
      r_tx_start <= w_start_nxt;
      r_busy     <= w_busy_nxt;
      r_tx_data  <= w_data_nxt;
    end
  end

  assign ack      = r_ack;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign gnt_id   = r_gnt_id;

endmodule

// File: tb/tb_tx_share_arbiter.sv
// Directed self-checking bench for tx_share_arbiter (STOP_CYCLES=1 main instance,
// plus a STOP_CYCLES=0 instance for the zero-gap case).
module tb_tx_share_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req = '0;
  logic [27:0] reqData = '0;
  logic [3:0]  ack;
  logic        txStart;
  logic [6:0]  txData;
  logic        busy;
  logic [1:0]  gntId;

  logic [3:0]  reqZ = '0;
  logic [27:0] reqDataZ = '0;
  logic [3:0]  ackZ;
  logic        txStartZ;
  logic [6:0]  txDataZ;
  logic        busyZ;
  logic [1:0]  gntIdZ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_share_arbiter #(.NREQ(4), .STOP_CYCLES(1)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_data(reqData), .ack(ack),
    .tx_start(txStart), .tx_data(txData), .busy(busy), .gnt_id(gntId)
  );

  tx_share_arbiter #(.NREQ(4), .STOP_CYCLES(0)) dutZ (
    .clk(clk), .rstn(rstn), .req(reqZ), .req_data(reqDataZ), .ack(ackZ),
    .tx_start(txStartZ), .tx_data(txDataZ), .busy(busyZ), .gnt_id(gntIdZ)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and sample 1ns after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rstn = 1'b0;
    req  = '0;
    reqZ = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Expected winners for a persistent request pattern after reset.
  function automatic int expAll(input int g);
`ifdef TX_SHARE_FIXED_PRIO_EN
    return 0;
`else
    return g % 4;
`endif
  endfunction

  function automatic int expPair(input int g);
`ifdef TX_SHARE_FIXED_PRIO_EN
    return 0;
`else
    return (g % 2 == 0) ? 0 : 2;
`endif
  endfunction

  initial begin
    // Reset state
    #3;
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_start", 32'(txStart), 32'h0);
    checkOutput("rst_data", 32'(txData), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_gnt", 32'(gntId), 32'h0);
    applyReset();

    // All four requesting: 10-cycle spacing, busy held
    req = 4'b1111;
    reqData = {7'h44, 7'h33, 7'h22, 7'h11};
    applyStimulus();
    checkOutput("all_ack0", 32'(ack), 32'(4'b1 << expAll(0)));
    checkOutput("all_gnt0", 32'(gntId), 32'(expAll(0)));
    for (int g = 1; g <= 4; g++) begin
      for (int c = 1; c <= 10; c++) begin
        applyStimulus();
        checkOutput($sformatf("all_ack g%0d c%0d", g, c), 32'(ack),
                    (c == 10) ? 32'(4'b1 << expAll(g)) : 32'h0);
        checkOutput($sformatf("all_busy g%0d c%0d", g, c), 32'(busy), 32'h1);
      end
      checkOutput($sformatf("all_gnt g%0d", g), 32'(gntId), 32'(expAll(g)));
    end

    // Two persistent requesters alternate
    applyReset();
    req = 4'b0101;
    applyStimulus();
    checkOutput("pair_gnt0", 32'(gntId), 32'(expPair(0)));
    for (int g = 1; g <= 3; g++) begin
      repeat (9) applyStimulus();
      applyStimulus();
      checkOutput($sformatf("pair_ack g%0d", g), 32'(ack), 32'(4'b1 << expPair(g)));
      checkOutput($sformatf("pair_gnt g%0d", g), 32'(gntId), 32'(expPair(g)));
    end

    // Single request, payload changed after ack, return to idle
    applyReset();
    req = 4'b0010;
    reqData = '0;
    reqData[13:7] = 7'h55;
    applyStimulus();
    checkOutput("single_ack", 32'(ack), 32'h2);
    checkOutput("single_start", 32'(txStart), 32'h1);
    checkOutput("single_data", 32'(txData), 32'h55);
    checkOutput("single_busy", 32'(busy), 32'h1);
    checkOutput("single_gnt", 32'(gntId), 32'h1);
    req = 4'b0000;
    reqData[13:7] = 7'h00;
    applyStimulus();
    checkOutput("single_ack_clr", 32'(ack), 32'h0);
    checkOutput("single_start_clr", 32'(txStart), 32'h0);
    for (int c = 2; c <= 9; c++) begin
      applyStimulus();
      checkOutput($sformatf("single_hold c%0d", c), 32'(txData), 32'h55);
      checkOutput($sformatf("single_busy c%0d", c), 32'(busy), 32'h1);
    end
    applyStimulus();
    checkOutput("single_idle", 32'(busy), 32'h0);
    checkOutput("single_data_idle", 32'(txData), 32'h55);

    // Reset mid-frame, then requester 1 wins first
    req = 4'b0010;
    reqData[13:7] = 7'h2A;
    applyStimulus();
    checkOutput("mid_gnt", 32'(gntId), 32'h1);
    req = 4'b0000;
    repeat (4) applyStimulus();
    #2;
    rstn = 1'b0;
    req = 4'b1010;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    checkOutput("mid_rst_data", 32'(txData), 32'h0);
    checkOutput("mid_rst_gnt", 32'(gntId), 32'h0);
    checkOutput("mid_rst_start", 32'(txStart), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus();
    checkOutput("mid_after_ack", 32'(ack), 32'h2);
    checkOutput("mid_after_gnt", 32'(gntId), 32'h1);
    req = 4'b0000;

    // Zero gap: back-to-back frames 9 cycles apart
    reqZ = 4'b0011;
    reqDataZ = '0;
    reqDataZ[6:0]  = 7'h01;
    reqDataZ[13:7] = 7'h7F;
    applyStimulus();
    checkOutput("zero_ack0", 32'(ackZ), 32'h1);
    checkOutput("zero_data0", 32'(txDataZ), 32'h01);
    reqZ = 4'b0010;
    for (int c = 1; c <= 9; c++) begin
      applyStimulus();
      checkOutput($sformatf("zero_ack c%0d", c), 32'(ackZ), (c == 9) ? 32'h2 : 32'h0);
      checkOutput($sformatf("zero_data c%0d", c), 32'(txDataZ), (c == 9) ? 32'h7F : 32'h01);
    end
    checkOutput("zero_start", 32'(txStartZ), 32'h1);
    checkOutput("zero_gnt", 32'(gntIdZ), 32'h1);
    checkOutput("zero_busy", 32'(busyZ), 32'h1);
    reqZ = 4'b0000;
    repeat (3) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_share_arbiter.md
Name: tx_share_arbiter

Overview:
- Shares one 7-bit serial transmitter among NREQ requesters.
- Arbitrates pending requests and captures the winner's data.
- Issues a one-cycle start pulse to the transmitter and holds its data input stable for the whole frame.
- Enforces a minimum inter-frame gap of STOP_CYCLES idle-high bits.
- Sits between the message producers and the transmitter.
- The transmitter frame is: start bit, 7 data bits LSB first, even-parity bit; it can accept the next start 9 cycles after the previous one.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- STOP_CYCLES, 1: idle-high cycles inserted between the parity bit and the next start bit, 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- req  input  NREQ  level request per requester.
- req_data  input  7*NREQ  payload; requester i uses bits [7i+6:7i].
- ack  output  NREQ  one-hot one-cycle grant pulse; payload captured on the same edge.
- tx_start  output  1  start pulse to transmitter.
- tx_data  output  7  payload to transmitter.
- busy  output  1  high while a frame or gap is in progress.
- gnt_id  output  clog2(NREQ)  index of the last granted requester.

Behaviour:
- All outputs registered.
- Reset values: tx_start=0, tx_data=0, ack=0, busy=0, gnt_id=0. Internal last-grant pointer = NREQ-1, so requester 0 has top priority first. State = IDLE, cnt = 0.
- Reset asserted mid-frame aborts immediately to reset values. The transmitter shares rstn, and no partial frame is resumed.
- States:
  - IDLE: busy=0. If any req bit is high at an edge, a grant occurs.
  - FRAME: busy=1, and cnt decrements each edge while cnt!=0. On the edge where cnt==0:
    - if any req is high, a new grant occurs (stay in FRAME);
    - otherwise go to IDLE.
- Grant edge, with winner w:
  - ack[w]<=1 for one cycle.
  - tx_data <= req_data[w].
  - tx_start <= 1.
  - gnt_id <= w; pointer <= w.
  - cnt <= 8+STOP_CYCLES; state <= FRAME.
- tx_start clears on the next edge, so it is high exactly one cycle. The transmitter samples it on that edge (E0).
- Minimum grant-to-grant spacing is 9+STOP_CYCLES cycles. The next start is sampled at E0+9+STOP_CYCLES.
- tx_data is held constant from the grant until the next grant. It is never changed during the frame, because the transmitter reads the data bits on E1..E7.
- Round robin: search starts at pointer+1 mod NREQ; the first set req bit wins. This gives wrap-around at NREQ-1 → 0.
- Requests: req is level-sensitive and never cleared by the block. A requester that keeps req high after ack is re-queued at lowest priority.
- Payload after ack: req_data may change freely after ack, since the payload is already latched.
- Simultaneous requests on one edge: exactly one ack bit is set.
- A req falling before being granted is simply dropped; no memory.
- No back-pressure beyond the level req; ack is the only handshake.

Optional Feature:
- Macro: TX_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority, lowest set index wins. The pointer is not used for selection; gnt_id is still updated.
- Undefined (default): round robin as above.

Test Plan:
- Single request:
  - Stimulus: req=0010, req_data[13:7]=7'h55, NREQ=4, STOP_CYCLES=1.
  - Response: ack=0010 one cycle; tx_start one cycle; tx_data=7'h55 held.
  - With the transmitter attached, serial line reads 0,1,0,1,0,1,0,1,0 (parity 0), then idle 1.
- All four requesting:
  - Stimulus: req=1111 held.
  - Response: grants in order 0,1,2,3,0; ack pulses exactly 10 cycles apart; busy stays high throughout.
- Two persistent requesters:
  - Stimulus: req0 and req2 both held high.
  - Response: grants alternate 0,2,0,2; requesters 1 and 3 are never granted.
  - With TX_SHARE_FIXED_PRIO_EN defined: only requester 0 is granted.
- Zero gap:
  - Stimulus: STOP_CYCLES=0, two back-to-back requests with data 7'h01 then 7'h7F.
  - Response: serial line 0,1,0,0,0,0,0,0,1 immediately followed by 0,1,1,1,1,1,1,1,1; ack spacing 9 cycles.
- Payload change after ack:
  - Stimulus: req_data for the granted requester changes to 7'h00 one cycle after ack.
  - Response: tx_data keeps the original value until the next grant; serial bits are unchanged.
- Reset mid-frame:
  - Stimulus: rstn low for 2 cycles during data bit 3.
  - Response: all outputs at reset values asynchronously.
  - After release, with req=1010: requester 1 is granted first.
